// File: rtl/comp_pkg.sv
// comp_pkg: screen codes, fade level range and fade FSM states shared by layer_compositor
package comp_pkg;
  localparam logic [1:0] SCR_GAME     = 2'd0;
  localparam logic [1:0] SCR_COVER    = 2'd1;
  localparam logic [1:0] SCR_SUCCESS  = 2'd2;
  localparam logic [1:0] SCR_GAMEOVER = 2'd3;
  localparam int LEVEL_W = 5;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 5'd16;
  typedef enum logic [1:0] {FADE_IDLE, FADE_OUT, FADE_IN} fade_state_e;
endpackage

// File: rtl/comp_fade_ctrl.sv
// comp_fade_ctrl: frame-timed fade FSM owning cur_sel and level; built only with COMP_FADE_EN
`ifdef COMP_FADE_EN
module comp_fade_ctrl import comp_pkg::*; #(
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start_i,
  input  logic [1:0]         screen_sel_i,
  output logic [1:0]         cur_sel_o,
  output logic [LEVEL_W-1:0] level_o,
  output logic               fade_busy_o
);
  localparam int CNT_W = $clog2(FRAMES_PER_STEP + 1);
  fade_state_e state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d, level_dn;
  logic [1:0] cur_sel_q, cur_sel_d, target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic step;
  assign step     = frame_start_i && (cnt_q == CNT_W'(FRAMES_PER_STEP - 1));
  assign level_dn = (level_q == '0) ? '0 : level_q - 1'b1;
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    cur_sel_d = cur_sel_q;
    target_d  = target_q;
    cnt_d     = frame_start_i ? (step ? '0 : cnt_q + 1'b1) : cnt_q;
    case (state_q)
      FADE_IDLE: if (frame_start_i && screen_sel_i != cur_sel_q) begin
        target_d = screen_sel_i;
        state_d  = FADE_OUT;
        cnt_d    = '0;
      end
      FADE_OUT: begin
        target_d = screen_sel_i;
        if (step) begin
          level_d = level_dn;
          if (level_dn == '0) begin
            cur_sel_d = target_d;
            state_d   = FADE_IN;
            cnt_d     = '0;
          end
        end
      end
      FADE_IN: if (frame_start_i && screen_sel_i != cur_sel_q) begin
        target_d = screen_sel_i;
        state_d  = FADE_OUT;
        cnt_d    = '0;
      end else if (step) begin
        level_d = level_q + 1'b1;
        state_d = (level_d == LEVEL_MAX) ? FADE_IDLE : FADE_IN;
      end
      default: state_d = FADE_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FADE_IDLE;
      level_q   <= LEVEL_MAX;
      cur_sel_q <= SCR_COVER;
      target_q  <= SCR_COVER;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      cur_sel_q <= cur_sel_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
    end
  end
  assign cur_sel_o   = cur_sel_q;
  assign level_o     = level_q;
  assign fade_busy_o = (state_q != FADE_IDLE);
endmodule
`endif

// File: rtl/layer_compositor.sv
// layer_compositor: 2-stage N-layer sprite/screen compositor with colour key and fade scaling.
// Define COMP_FADE_EN to build the frame-timed fade-out/fade-in controller.
module layer_compositor import comp_pkg::*; #(
  parameter int              N_LAYERS        = 4,
  parameter int              RGB_W           = 12,
  parameter int              KEY_ENABLE      = 1,
  parameter logic [RGB_W-1:0] KEY_RGB        = 12'hF0F,
  parameter int              FRAMES_PER_STEP = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic                      video_off,
  input  logic                      game_en,
  input  logic [1:0]                screen_sel,
  input  logic [N_LAYERS-1:0]       layer_on,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [RGB_W-1:0]          bg_rgb,
  input  logic [3*RGB_W-1:0]        screen_rgb,
  output logic [RGB_W-1:0]          rgb,
  output logic [N_LAYERS-1:0]       layer_hit,
  output logic                      fade_busy
);
  localparam int CW = RGB_W / 3;
  if (FRAMES_PER_STEP < 1) begin : g_bad_fps
    $error("FRAMES_PER_STEP must be >= 1");
  end
  logic [1:0] cur_sel;
  logic [LEVEL_W-1:0] level;
`ifdef COMP_FADE_EN
  comp_fade_ctrl #(.FRAMES_PER_STEP(FRAMES_PER_STEP)) u_fade (
    .clk(clk), .reset(reset), .frame_start_i(frame_start), .screen_sel_i(screen_sel),
    .cur_sel_o(cur_sel), .level_o(level), .fade_busy_o(fade_busy)
  );
`else
  logic [1:0] cur_sel_q;
  always_ff @(posedge clk) begin
    if (reset) cur_sel_q <= SCR_COVER;
    else if (frame_start) cur_sel_q <= screen_sel;
  end
  assign cur_sel   = cur_sel_q;
  assign level     = LEVEL_MAX;
  assign fade_busy = 1'b0;
`endif
  logic voff_q, game_q;
  logic [RGB_W-1:0] bg_q, scr_q, scr_d, base, faded, rgb_q;
  logic [N_LAYERS-1:0] q_q, q_d, hit, hit_q;
  logic [N_LAYERS*RGB_W-1:0] lrgb_q;
  logic [RGB_W-1:0] acc [N_LAYERS+1];
  assign scr_d = (cur_sel == SCR_SUCCESS)  ? screen_rgb[RGB_W +: RGB_W] :
                 (cur_sel == SCR_GAMEOVER) ? screen_rgb[2*RGB_W +: RGB_W] : screen_rgb[0 +: RGB_W];
  assign acc[0] = '0;
  for (genvar i = 0; i < N_LAYERS; i++) begin : g_layer
    assign q_d[i] = layer_on[i] & game_en & (cur_sel == SCR_GAME) &
                    ~((KEY_ENABLE != 0) && (layer_rgb[i*RGB_W +: RGB_W] == KEY_RGB));
    if (i == 0) begin : g_top
      assign hit[i] = q_q[i];
    end else begin : g_rest
      assign hit[i] = q_q[i] & ~|q_q[i-1:0];
    end
    assign acc[i+1] = acc[i] | (hit[i] ? lrgb_q[i*RGB_W +: RGB_W] : '0);
  end
  assign base = voff_q ? '0 : !game_q ? scr_q : |hit ? acc[N_LAYERS] : bg_q;
  // Per-channel (c*level)>>4 truncation; level 16 passes the pixel through.
  for (genvar c = 0; c < 3; c++) begin : g_chan
    logic [CW+LEVEL_W-1:0] prod;
    assign prod = (CW+LEVEL_W)'(base[c*CW +: CW]) * (CW+LEVEL_W)'(level);
    assign faded[c*CW +: CW] = prod[CW+3:4];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      voff_q <= 1'b0;
      game_q <= 1'b0;
      bg_q   <= '0;
      scr_q  <= '0;
      q_q    <= '0;
      lrgb_q <= '0;
      rgb_q  <= '0;
      hit_q  <= '0;
    end else begin
      voff_q <= video_off;
      game_q <= (cur_sel == SCR_GAME);
      bg_q   <= bg_rgb;
      scr_q  <= scr_d;
      q_q    <= q_d;
      lrgb_q <= layer_rgb;
      rgb_q  <= faded;
      hit_q  <= voff_q ? '0 : hit;
    end
  end
  assign rgb       = rgb_q;
  assign layer_hit = hit_q;
endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: randomized and directed checks of layer_compositor against a pixel-rule model
module tb_layer_compositor;
  logic clk = 1'b0, reset = 1'b1, frame_start = 1'b0, video_off = 1'b0, game_en = 1'b0;
  logic [1:0] screen_sel = 2'd1;
  logic [3:0] layer_on = '0;
  logic [47:0] layer_rgb = '0;
  logic [11:0] bg_rgb = '0;
  logic [35:0] screen_rgb = '0;
  logic [11:0] rgb, rgb_nk;
  logic [3:0] layer_hit, hit_nk;
  logic fade_busy, busy_nk;
  int vectors = 0, errors = 0;
  int m_sel = 1;
  typedef struct {logic [11:0] r; logic [3:0] h; logic [11:0] rn; logic [3:0] hn;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  layer_compositor #(.KEY_ENABLE(1), .FRAMES_PER_STEP(1)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .video_off(video_off), .game_en(game_en),
    .screen_sel(screen_sel), .layer_on(layer_on), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
    .screen_rgb(screen_rgb), .rgb(rgb), .layer_hit(layer_hit), .fade_busy(fade_busy));
  layer_compositor #(.KEY_ENABLE(0), .FRAMES_PER_STEP(1)) dut_nk (
    .clk(clk), .reset(reset), .frame_start(frame_start), .video_off(video_off), .game_en(game_en),
    .screen_sel(screen_sel), .layer_on(layer_on), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
    .screen_rgb(screen_rgb), .rgb(rgb_nk), .layer_hit(hit_nk), .fade_busy(busy_nk));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference pixel at full level: blank, else full screen, else first opaque enabled layer, else background.
  function automatic void model(input logic voff, input logic ge, input int sel, input logic [3:0] on,
                                input logic [47:0] lr, input logic [11:0] bg, input logic [35:0] scr,
                                input bit key_en, output logic [11:0] r, output logic [3:0] h);
    r = 12'h000;
    h = 4'b0000;
    if (voff) return;
    if (sel != 0) begin
      r = scr[(sel-1)*12 +: 12];
      return;
    end
    r = bg;
    if (!ge) return;
    for (int i = 0; i < 4; i++) begin
      if (on[i] && !(key_en && lr[i*12 +: 12] == 12'hF0F)) begin
        r = lr[i*12 +: 12];
        h = 4'b0001 << i;
        return;
      end
    end
  endfunction

  function automatic logic [11:0] grey(input int lvl);
    logic [3:0] c;
    c = 4'((15 * lvl) >> 4);
    return {c, c, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic goto_screen(input int s);
    screen_sel = 2'(s);
    pulse();
`ifdef COMP_FADE_EN
    for (int i = 0; i < 40 && fade_busy; i++) pulse();
    vectors++;
    if (fade_busy !== 1'b0) begin
      errors++;
      $display("FAIL goto_screen_%0d: fade_busy=%b after 40 frames, want 0", s, fade_busy);
    end
`endif
    m_sel = s;
    tick();
    tick();
  endtask

  task automatic test_reset();
    screen_rgb = {12'hABC, 12'h5A5, 12'h3C3};
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_sel = 1;
    vectors += 3;
    if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h want 000", rgb); end
    if (layer_hit !== 4'b0) begin errors++; $display("FAIL reset_hit: got %b want 0000", layer_hit); end
    if (fade_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", fade_busy); end
    tick();
    tick();
    vectors++;
    if (rgb !== 12'h3C3) begin errors++; $display("FAIL reset_cover: got %h want 3C3", rgb); end
  endtask

  task automatic test_priority();
    goto_screen(0);
    game_en = 1'b1;
    bg_rgb = 12'h321;
    layer_on = 4'b0000;
    layer_rgb = {12'h777, 12'h00F, 12'h0F0, 12'h456};
    tick();
    tick();
    layer_on = 4'b0110;
    tick();
    vectors++;
    if (rgb !== 12'h321) begin errors++; $display("FAIL prio_latency1: got %h want 321", rgb); end
    tick();
    vectors += 2;
    if (rgb !== 12'h0F0) begin errors++; $display("FAIL prio_rgb: got %h want 0F0", rgb); end
    if (layer_hit !== 4'b0010) begin errors++; $display("FAIL prio_hit: got %b want 0010", layer_hit); end
  endtask

  task automatic test_key();
    layer_on = 4'b0001;
    layer_rgb = {12'h777, 12'h00F, 12'h0F0, 12'hF0F};
    bg_rgb = 12'h123;
    tick();
    tick();
    vectors += 4;
    if (rgb !== 12'h123) begin errors++; $display("FAIL key_rgb: got %h want 123", rgb); end
    if (layer_hit !== 4'b0) begin errors++; $display("FAIL key_hit: got %b want 0000", layer_hit); end
    if (rgb_nk !== 12'hF0F) begin errors++; $display("FAIL nokey_rgb: got %h want F0F", rgb_nk); end
    if (hit_nk !== 4'b0001) begin errors++; $display("FAIL nokey_hit: got %b want 0001", hit_nk); end
  endtask

  task automatic test_screens();
    layer_on = 4'hF;
    game_en = 1'b1;
    goto_screen(3);
    vectors += 2;
    if (rgb !== 12'hABC) begin errors++; $display("FAIL screen_rgb: got %h want ABC", rgb); end
    if (layer_hit !== 4'b0) begin errors++; $display("FAIL screen_hit: got %b want 0000", layer_hit); end
    video_off = 1'b1;
    tick();
    tick();
    vectors += 2;
    if (rgb !== 12'h000) begin errors++; $display("FAIL voff_rgb: got %h want 000", rgb); end
    if (layer_hit !== 4'b0) begin errors++; $display("FAIL voff_hit: got %b want 0000", layer_hit); end
    video_off = 1'b0;
  endtask

  task automatic test_random();
    exp_t e;
    goto_screen(0);
    sb.delete();
    for (int n = 0; n < 400; n++) begin
      layer_on = 4'($urandom);
      for (int i = 0; i < 4; i++)
        layer_rgb[i*12 +: 12] = ($urandom_range(3) == 0) ? 12'hF0F : 12'($urandom);
      game_en = ($urandom_range(9) != 0);
      video_off = ($urandom_range(9) == 0);
      bg_rgb = 12'($urandom);
      screen_rgb = 36'($urandom) ^ (36'($urandom) << 20);
`ifndef COMP_FADE_EN
      frame_start = ($urandom_range(15) == 0);
      screen_sel = ($urandom_range(1) == 0) ? 2'd0 : 2'($urandom);
`endif
      model(video_off, game_en, m_sel, layer_on, layer_rgb, bg_rgb, screen_rgb, 1'b1, e.r, e.h);
      model(video_off, game_en, m_sel, layer_on, layer_rgb, bg_rgb, screen_rgb, 1'b0, e.rn, e.hn);
      sb.push_back(e);
      tick();
      if (frame_start) m_sel = int'(screen_sel);
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        vectors++;
        if (rgb !== e.r || layer_hit !== e.h || rgb_nk !== e.rn || hit_nk !== e.hn) begin
          errors++;
          $display("FAIL random_%0d: got rgb=%h hit=%b nk_rgb=%h nk_hit=%b want rgb=%h hit=%b nk_rgb=%h nk_hit=%b",
                   n, rgb, layer_hit, rgb_nk, hit_nk, e.r, e.h, e.rn, e.hn);
        end
      end
    end
    frame_start = 1'b0;
    video_off = 1'b0;
  endtask

`ifdef COMP_FADE_EN
  task automatic test_fade();
    int lvl;
    game_en = 1'b0;
    layer_on = 4'b0;
    bg_rgb = 12'hFFF;
    screen_rgb = {3{12'hFFF}};
    screen_sel = 2'd1;
    pulse();
    vectors++;
    if (fade_busy !== 1'b1) begin errors++; $display("FAIL fade_start_busy: got %b want 1", fade_busy); end
    for (int k = 1; k <= 32; k++) begin
      pulse();
      tick();
      tick();
      lvl = (k <= 16) ? 16 - k : k - 16;
      vectors += 2;
      if (rgb !== grey(lvl)) begin errors++; $display("FAIL fade_level_f%0d: got %h want %h", k, rgb, grey(lvl)); end
      if (fade_busy !== (k < 32)) begin errors++; $display("FAIL fade_busy_f%0d: got %b want %b", k, fade_busy, k < 32); end
      if (k == 8) begin
        vectors++;
        if (rgb !== 12'h777) begin errors++; $display("FAIL fade_half: got %h want 777", rgb); end
      end
    end
    m_sel = 1;
  endtask

  task automatic test_reversal();
    screen_sel = 2'd0;
    pulse();
    for (int k = 0; k < 21; k++) pulse();
    tick();
    tick();
    vectors++;
    if (rgb !== grey(5)) begin errors++; $display("FAIL rev_in5: got %h want %h", rgb, grey(5)); end
    screen_sel = 2'd2;
    pulse();
    tick();
    tick();
    vectors += 2;
    if (rgb !== grey(5)) begin errors++; $display("FAIL rev_hold5: got %h want %h", rgb, grey(5)); end
    if (fade_busy !== 1'b1) begin errors++; $display("FAIL rev_busy: got %b want 1", fade_busy); end
    for (int k = 1; k <= 5; k++) begin
      pulse();
      tick();
      tick();
      vectors++;
      if (rgb !== grey(5 - k)) begin errors++; $display("FAIL rev_out_s%0d: got %h want %h", k, rgb, grey(5 - k)); end
    end
    for (int k = 0; k < 16; k++) pulse();
    screen_rgb[12 +: 12] = 12'h5A5;
    tick();
    tick();
    vectors += 2;
    if (rgb !== 12'h5A5) begin errors++; $display("FAIL rev_success: got %h want 5A5", rgb); end
    if (fade_busy !== 1'b0) begin errors++; $display("FAIL rev_idle: got %b want 0", fade_busy); end
    m_sel = 2;
  endtask

  task automatic test_mid_reset();
    screen_rgb = {3{12'hFFF}};
    screen_sel = 2'd1;
    pulse();
    for (int k = 0; k < 9; k++) pulse();
    tick();
    tick();
    vectors++;
    if (rgb !== grey(7)) begin errors++; $display("FAIL midrst_l7: got %h want %h", rgb, grey(7)); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors += 2;
    if (rgb !== 12'h000) begin errors++; $display("FAIL midrst_rgb: got %h want 000", rgb); end
    if (fade_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", fade_busy); end
    screen_rgb[0 +: 12] = 12'h3C3;
    tick();
    tick();
    vectors++;
    if (rgb !== 12'h3C3) begin errors++; $display("FAIL midrst_cover: got %h want 3C3", rgb); end
    m_sel = 1;
  endtask
`endif

  initial begin
    test_reset();
    test_priority();
    test_key();
    test_screens();
    test_random();
`ifdef COMP_FADE_EN
    test_fade();
    test_reversal();
    test_mid_reset();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
